// File: rtl/key_scan_pkg.sv
// Shared types and defaults for the key scanner front end.
// Latency: n/a (types only).  Backpressure: n/a.
package key_scan_pkg;

    localparam int N_KEYS_DEF    = 10;
    localparam int DEBOUNCE_DEF  = 4;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } scan_state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus per-vector debounce; emits the last stable key vector.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 from key_in change to stable update.
// Backpressure: none; free-running, every cycle.
module key_debounce
    import key_scan_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] stable
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] s1_q, s1_d;
    logic [N_KEYS-1:0] s2_q, s2_d;
    logic [N_KEYS-1:0] cand_q, cand_d;
    logic [N_KEYS-1:0] stable_q, stable_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        s1_d     = key_in;
        s2_d     = s1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        // Whole vector is debounced as one unit: any bit change restarts the window.
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != DB_MAX) begin
                cnt_d = cnt_q + DB_W'(1);
            end
            if (cnt_q == DB_MAX) begin
                stable_d = cand_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/key_onehot_scanner.sv
// Turns debounced key vectors into one registered one-hot press per key-down.
// Latency: key_in held -> onehot_valid after DEBOUNCE_CYCLES+4 edges.
// Backpressure: onehot_out/onehot_valid held until onehot_valid && onehot_ready.
module key_onehot_scanner
    import key_scan_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] onehot_out,
    output logic              onehot_valid,
    input  logic              onehot_ready,
    output logic              multi_err,
    output logic [CNT_W-1:0]  press_count
);

    logic [N_KEYS-1:0] stable;
    logic              stable_any;
    logic              stable_single;

    scan_state_t       state_q, state_d;
    logic [N_KEYS-1:0] onehot_q, onehot_d;
    logic              valid_q, valid_d;
    logic              multi_q, multi_d;
    logic [CNT_W-1:0]  count_q, count_d;

    key_debounce #(
        .N_KEYS          (N_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .stable (stable)
    );

    assign stable_any    = (stable != '0);
    // Clearing the lowest set bit leaves zero only for a single-hot vector.
    assign stable_single = stable_any && ((stable & (stable - N_KEYS'(1))) == '0);

    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        multi_d  = 1'b0;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (stable_single) begin
                    onehot_d = stable;
                    valid_d  = 1'b1;
                    state_d  = EMIT;
                end else if (stable_any) begin
                    multi_d  = 1'b1;
                    state_d  = HOLD;
                end
            end
            EMIT: begin
                if (valid_q && onehot_ready) begin
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    count_d  = count_q + CNT_W'(1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!stable_any) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
                valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
            count_q  <= count_d;
        end
    end

    assign onehot_out   = onehot_q;
    assign onehot_valid = valid_q;
    assign multi_err    = multi_q;
    assign press_count  = count_q;

endmodule
